// File: rtl/arm_mc_controller.sv
// arm_mc_controller: multicycle control unit for the ARM core.
// Runs the per-instruction sequence, holds the NZCV flags, evaluates
// condition codes and drives every datapath enable and mux select.
// Build option: define ARM_MC_MEMREADY_EN to honour the MemReady handshake.
// When it is undefined, MemReady is ignored and every memory access
// completes in a single cycle.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <- PC+4 when memory is ready
// DECODE   | read registers, pick the instruction class
// MEMADR   | compute load/store address (Rn + imm)
// MEMREAD  | read data memory, stall until ready
// MEMWB    | write loaded data to Rd
// MEMWRITE | write data memory, stall until ready
// EXECR    | data-processing with register operand B
// EXECI    | data-processing with immediate operand B
// ALUWB    | write ALU result to Rd (or PC)
// BRANCH   | PC <- PC+8+imm when the condition holds
module arm_mc_controller #(
   parameter int ALUC_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [19:0]       Instr,
   input  logic [3:0]        ALUFlags,
   input  logic              MemReady,
   output logic              PCWrite,
   output logic              MemWrite,
   output logic              RegWrite,
   output logic              IRWrite,
   output logic              AdrSrc,
   output logic              ALUSrcA,
   output logic [1:0]        ALUSrcB,
   output logic [1:0]        ResultSrc,
   output logic [1:0]        RegSrc,
   output logic [1:0]        ImmSrc,
   output logic [ALUC_W-1:0] ALUControl,
   output logic              Retire,
   output logic [3:0]        State
);

   localparam logic [3:0] FETCH    = 4'd0;
   localparam logic [3:0] DECODE   = 4'd1;
   localparam logic [3:0] MEMADR   = 4'd2;
   localparam logic [3:0] MEMREAD  = 4'd3;
   localparam logic [3:0] MEMWB    = 4'd4;
   localparam logic [3:0] MEMWRITE = 4'd5;
   localparam logic [3:0] EXECR    = 4'd6;
   localparam logic [3:0] EXECI    = 4'd7;
   localparam logic [3:0] ALUWB    = 4'd8;
   localparam logic [3:0] BRANCH   = 4'd9;

   logic [3:0]        state;
   logic [3:0]        next_state;
   logic [3:0]        flags;
   logic              cond_ex_q;

   // Instr carries bits [31:12] of the instruction, so bit k sits at k-12.
   logic [3:0]        cond;
   logic [1:0]        op;
   logic              i_bit;
   logic [3:0]        cmd;
   logic              s_bit;
   logic [3:0]        rd;
   logic [3:0]        unused_rn;

   assign cond      = Instr[19:16];
   assign op        = Instr[15:14];
   assign i_bit     = Instr[13];
   assign cmd       = Instr[12:9];
   assign s_bit     = Instr[8];
   assign unused_rn = Instr[7:4];
   assign rd        = Instr[3:0];

   logic mem_ready;
`ifdef ARM_MC_MEMREADY_EN
   assign mem_ready = MemReady;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = MemReady;
   assign mem_ready        = 1'b1;
`endif

   logic [ALUC_W-1:0] alu_dec;
   logic              cmd_ok;
   logic              no_write;
   logic              force_s;
   logic              cv_cmd;

   // ALU operation decode from cmd; unsupported commands map to ADD with all writes blocked
   always_comb begin
      alu_dec  = '0;
      cmd_ok   = 1'b1;
      no_write = 1'b0;
      force_s  = 1'b0;
      cv_cmd   = 1'b0;
      case (cmd)
         4'b0100: begin alu_dec = ALUC_W'(0); cv_cmd = 1'b1; end
         4'b0010: begin alu_dec = ALUC_W'(1); cv_cmd = 1'b1; end
         4'b0000: alu_dec = ALUC_W'(2);
         4'b1100: alu_dec = ALUC_W'(3);
         4'b1010: begin
            alu_dec  = ALUC_W'(1);
            no_write = 1'b1;
            force_s  = 1'b1;
            cv_cmd   = 1'b1;
         end
         4'b0001: begin
            if (ALUC_W >= 3) alu_dec = ALUC_W'(4);
            else             cmd_ok  = 1'b0;
         end
         4'b1101: begin
            if (ALUC_W >= 3) alu_dec = ALUC_W'(5);
            else             cmd_ok  = 1'b0;
         end
         4'b1000: begin
            if (ALUC_W >= 3) begin
               alu_dec  = ALUC_W'(2);
               no_write = 1'b1;
               force_s  = 1'b1;
            end else begin
               cmd_ok = 1'b0;
            end
         end
         default: cmd_ok = 1'b0;
      endcase
   end

   logic flag_n, flag_z, flag_c, flag_v;
   logic cond_ex_live;
   logic cond_ex;

   assign {flag_n, flag_z, flag_c, flag_v} = flags;

   // ARM condition-code evaluation against the registered flags
   always_comb begin
      cond_ex_live = 1'b0;
      case (cond)
         4'h0: cond_ex_live = flag_z;
         4'h1: cond_ex_live = ~flag_z;
         4'h2: cond_ex_live = flag_c;
         4'h3: cond_ex_live = ~flag_c;
         4'h4: cond_ex_live = flag_n;
         4'h5: cond_ex_live = ~flag_n;
         4'h6: cond_ex_live = flag_v;
         4'h7: cond_ex_live = ~flag_v;
         4'h8: cond_ex_live = flag_c & ~flag_z;
         4'h9: cond_ex_live = ~flag_c | flag_z;
         4'hA: cond_ex_live = (flag_n == flag_v);
         4'hB: cond_ex_live = (flag_n != flag_v);
         4'hC: cond_ex_live = ~flag_z & (flag_n == flag_v);
         4'hD: cond_ex_live = flag_z | (flag_n != flag_v);
         4'hE: cond_ex_live = 1'b1;
         default: cond_ex_live = 1'b0;
      endcase
   end

   // An S-suffixed instruction may change the flags it was conditioned on,
   // so its writeback uses the condition as it stood during execute.
   assign cond_ex = (state == ALUWB) ? cond_ex_q : cond_ex_live;

   logic exec_st;
   logic flag_nz_we;
   logic flag_cv_we;

   assign exec_st    = (state == EXECR) || (state == EXECI);
   assign flag_nz_we = exec_st & (s_bit | force_s) & cond_ex_live & cmd_ok;
   assign flag_cv_we = flag_nz_we & cv_cmd;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= next_state;
   end

   // Flag register and execute-time condition snapshot
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags     <= 4'b0000;
         cond_ex_q <= 1'b0;
      end else if (exec_st) begin
         cond_ex_q <= cond_ex_live;
         if (flag_nz_we) flags[3:2] <= ALUFlags[3:2];
         if (flag_cv_we) flags[1:0] <= ALUFlags[1:0];
      end
   end

   logic pc_w, mem_w, reg_w, ir_w, retire_i;
   logic alu_wb_ok;

   assign alu_wb_ok = cond_ex & ~no_write & cmd_ok;

   // Next-state logic and per-state Moore outputs
   always_comb begin
      next_state = FETCH;
      pc_w       = 1'b0;
      mem_w      = 1'b0;
      reg_w      = 1'b0;
      ir_w       = 1'b0;
      retire_i   = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ALUControl = '0;
      case (state)
         FETCH: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            ResultSrc  = 2'b10;
            ir_w       = mem_ready;
            pc_w       = mem_ready;
            next_state = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            case (op)
               2'b01:   next_state = MEMADR;
               2'b00:   next_state = i_bit ? EXECI : EXECR;
               2'b10:   next_state = BRANCH;
               default: begin
                  next_state = FETCH;
                  retire_i   = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            ALUSrcB    = 2'b01;
            next_state = s_bit ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            AdrSrc     = 1'b1;
            next_state = mem_ready ? MEMWB : MEMREAD;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            reg_w     = cond_ex;
            retire_i  = 1'b1;
         end
         MEMWRITE: begin
            AdrSrc     = 1'b1;
            mem_w      = cond_ex;
            retire_i   = mem_ready;
            next_state = mem_ready ? FETCH : MEMWRITE;
         end
         EXECR: begin
            ALUControl = alu_dec;
            next_state = ALUWB;
         end
         EXECI: begin
            ALUSrcB    = 2'b01;
            ALUControl = alu_dec;
            next_state = ALUWB;
         end
         ALUWB: begin
            reg_w    = alu_wb_ok;
            pc_w     = alu_wb_ok & (rd == 4'd15);
            retire_i = 1'b1;
         end
         BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            pc_w      = cond_ex;
            retire_i  = 1'b1;
         end
         default: next_state = FETCH;
      endcase
   end

   // Write enables and Retire are forced low while reset is held, so an
   // abandoned instruction cannot write in the cycle reset arrives.
   assign PCWrite  = pc_w & ~reset;
   assign MemWrite = mem_w & ~reset;
   assign RegWrite = reg_w & ~reset;
   assign IRWrite  = ir_w & ~reset;
   assign Retire   = retire_i & ~reset;

   assign ImmSrc = op;
   assign RegSrc = {op == 2'b01, op == 2'b10};
   assign State  = state;

endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed bench for arm_mc_controller: runs hand-coded instructions and
// compares state sequences, enables and selects with expected values.
module tb_arm_mc_controller;

`ifdef ARM_MC_MEMREADY_EN
   localparam bit HAS_MR = 1'b1;
`else
   localparam bit HAS_MR = 1'b0;
`endif
   localparam int MAXC = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [19:0] Instr;
   logic [3:0]  ALUFlags;
   logic        MemReady;

   logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, Retire;
   logic [1:0] ALUSrcB, ResultSrc, RegSrc, ImmSrc;
   logic [1:0] ALUControl;
   logic [3:0] State;

   logic       PCWrite3, MemWrite3, RegWrite3, IRWrite3, AdrSrc3, ALUSrcA3, Retire3;
   logic [1:0] ALUSrcB3, ResultSrc3, RegSrc3, ImmSrc3;
   logic [2:0] ALUControl3;
   logic [3:0] State3;

   arm_mc_controller #(.ALUC_W(2)) dut (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
      .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
      .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Retire(Retire), .State(State)
   );

   arm_mc_controller #(.ALUC_W(3)) dut3 (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
      .PCWrite(PCWrite3), .MemWrite(MemWrite3), .RegWrite(RegWrite3), .IRWrite(IRWrite3),
      .AdrSrc(AdrSrc3), .ALUSrcA(ALUSrcA3), .ALUSrcB(ALUSrcB3), .ResultSrc(ResultSrc3),
      .RegSrc(RegSrc3), .ImmSrc(ImmSrc3), .ALUControl(ALUControl3), .Retire(Retire3), .State(State3)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [3:0]      st_h [MAXC];
   logic [1:0]      rs_h [MAXC];
   logic [1:0]      ac_h [MAXC];
   logic [2:0]      ac3_h [MAXC];
   logic [MAXC-1:0] rw_h, pcw_h, mw_h, rw3_h, ret_h;
   int              ncyc;

   // Run one instruction from FETCH to its Retire pulse, recording outputs per cycle.
   // MemReady is dropped for stall_n cycles whenever the state equals stall_st.
   task automatic run_instr(input logic [19:0] ins, input logic [3:0] flg,
                            input int stall_st, input int stall_n);
      int  left;
      bit  done;
      left  = stall_n;
      done  = 1'b0;
      ncyc  = 0;
      rw_h  = '0; pcw_h = '0; mw_h = '0; rw3_h = '0; ret_h = '0;
      Instr    = ins;
      ALUFlags = flg;
      for (int k = 0; k < MAXC && !done; k++) begin
         MemReady = 1'b1;
         #1;
         if (int'(State) == stall_st && left > 0) begin
            MemReady = 1'b0;
            left--;
         end
         #1;
         st_h[k]  = State;
         rs_h[k]  = ResultSrc;
         ac_h[k]  = ALUControl;
         ac3_h[k] = ALUControl3;
         rw_h[k]  = RegWrite;
         pcw_h[k] = PCWrite;
         mw_h[k]  = MemWrite;
         rw3_h[k] = RegWrite3;
         ret_h[k] = Retire;
         ncyc     = k + 1;
         if (Retire) done = 1'b1;
         @(posedge clk);
         #1;
      end
      MemReady = 1'b1;
      if (!done) check("retire_timeout", 32'd0, 32'd1);
   endtask

   int exp_ldr;

   initial begin
      reset    = 1'b1;
      Instr    = 20'hE2821;
      ALUFlags = 4'b0000;
      MemReady = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      check("rst_state",   {28'd0, State}, 32'd0);
      check("rst_irwrite", {31'd0, IRWrite}, 32'd0);
      check("rst_pcwrite", {31'd0, PCWrite}, 32'd0);
      check("rst_retire",  {31'd0, Retire}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // ADD R1,R2,#5
      run_instr(20'hE2821, 4'b0000, -1, 0);
      check("add_cycles", ncyc, 4);
      check("add_st0", {28'd0, st_h[0]}, 0);
      check("add_st1", {28'd0, st_h[1]}, 1);
      check("add_st2", {28'd0, st_h[2]}, 7);
      check("add_st3", {28'd0, st_h[3]}, 8);
      check("add_rw", {16'd0, rw_h}, 32'h8);
      check("add_aluctl", {30'd0, ac_h[2]}, 0);
      check("add_retire", {16'd0, ret_h}, 32'h8);

      // LDR R1,[R0] with two stall cycles in MEMREAD
      exp_ldr = HAS_MR ? 7 : 5;
      run_instr(20'hE5901, 4'b0000, 3, 2);
      check("ldr_cycles", ncyc, exp_ldr);
      check("ldr_last_st", {28'd0, st_h[exp_ldr-1]}, 4);
      check("ldr_rw", {16'd0, rw_h}, 32'd1 << (exp_ldr - 1));
      check("ldr_rsrc", {30'd0, rs_h[exp_ldr-1]}, 1);

      // STR R1,[R0] with one stall cycle in MEMWRITE
      run_instr(20'hE5801, 4'b0000, 5, 1);
      check("str_cycles", ncyc, HAS_MR ? 5 : 4);
      check("str_mw", {16'd0, mw_h}, HAS_MR ? 32'h18 : 32'h8);

      // CMP R0,R1 giving Z=1
      run_instr(20'hE1500, 4'b0100, -1, 0);
      check("cmp_cycles", ncyc, 4);
      check("cmp_aluctl", {30'd0, ac_h[2]}, 1);
      check("cmp_rw", {16'd0, rw_h}, 0);

      run_instr(20'h1AFFF, 4'b0000, -1, 0);
      check("bne_cycles", ncyc, 3);
      check("bne_state", {28'd0, st_h[2]}, 9);
      check("bne_pcw", {16'd0, pcw_h}, 32'h1);
      run_instr(20'h0AFFF, 4'b0000, -1, 0);
      check("beq_pcw", {16'd0, pcw_h}, 32'h5);

      // SUBS R0,R0,R1 with N=1,V=1, then ADD without S
      run_instr(20'hE0500, 4'b1001, -1, 0);
      check("subs_aluctl", {30'd0, ac_h[2]}, 1);
      check("subs_rw", {16'd0, rw_h}, 32'h8);
      run_instr(20'hE2821, 4'b0110, -1, 0);
      run_instr(20'h4AFFF, 4'b0000, -1, 0);
      check("bmi_pcw", {16'd0, pcw_h}, 32'h5);
      run_instr(20'h6AFFF, 4'b0000, -1, 0);
      check("bvs_pcw", {16'd0, pcw_h}, 32'h5);
      run_instr(20'h0AFFF, 4'b0000, -1, 0);
      check("beq_after_subs", {16'd0, pcw_h}, 32'h1);
      run_instr(20'hBAFFF, 4'b0000, -1, 0);
      check("blt_pcw", {16'd0, pcw_h}, 32'h1);

      // EOR R0,R0,R1: unsupported at ALUC_W=2, code 4 at ALUC_W=3
      run_instr(20'hE0200, 4'b0000, -1, 0);
      check("eor2_rw", {16'd0, rw_h}, 0);
      check("eor2_aluctl", {30'd0, ac_h[2]}, 0);
      check("eor3_aluctl", {29'd0, ac3_h[2]}, 4);
      check("eor3_rw", {16'd0, rw3_h}, 32'h8);

      // ADD PC,R2,#5 writes PC in ALUWB
      run_instr(20'hE282F, 4'b0000, -1, 0);
      check("addpc_pcw", {16'd0, pcw_h}, 32'h9);

      // ADDNV: full cycle count, no writes
      run_instr(20'hF2821, 4'b0000, -1, 0);
      check("nv_cycles", ncyc, 4);
      check("nv_rw", {16'd0, rw_h}, 0);

      // Op=11
      run_instr(20'hEC000, 4'b0000, -1, 0);
      check("op11_cycles", ncyc, 2);
      check("op11_rw", {16'd0, rw_h | pcw_h | mw_h}, 32'h1);

      // Reset while stalled in MEMWRITE
      Instr    = 20'hE5801;
      MemReady = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
      end
      MemReady = 1'b0;
      #1;
      check("mw_before_rst", {28'd0, State, 3'd0, MemWrite}, 32'h51);
      reset = 1'b1;
      #1;
      check("mw_at_rst", {31'd0, MemWrite}, 0);
      check("state_at_rst", {28'd0, State}, 0);
      @(posedge clk);
      #2;
      check("en_in_rst", {28'd0, PCWrite, MemWrite, RegWrite, IRWrite}, 0);
      @(posedge clk);
      #1;
      reset    = 1'b0;
      MemReady = 1'b1;
      run_instr(20'hE2821, 4'b0000, -1, 0);
      check("add_after_rst", ncyc, 4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/arm_mc_controller.md
# arm_mc_controller

Multicycle control unit for the next-generation ARM core. It replaces the single-cycle controller so that one shared instruction/data memory can be used. It runs a per-instruction state machine (fetch, decode, execute, memory, writeback) and stalls on a memory ready handshake. It holds the condition flags, evaluates ARM condition codes, and drives all datapath enables and muxes. The ALU operation set is width-parametrised.

## Interface
- ALUC_W, 2, ALUControl width; 2 = ADD/SUB/AND/ORR/CMP; 3 adds EOR/MOV/TST
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; state→FETCH, Flags→0
- Instr  in  20  instruction bits [31:12] from instruction register
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- MemReady  in  1  memory completes access this cycle
- PCWrite, MemWrite, RegWrite, IRWrite  out  1 each  datapath write enables
- AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address
- ALUSrcA  out  1  0 = register A, 1 = PC
- ALUSrcB  out  2  00 reg B, 01 ExtImm, 10 constant 4
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- RegSrc, ImmSrc  out  2 each  register-address / immediate-extend selects
- ALUControl  out  ALUC_W  ALU operation
- Retire  out  1  one-cycle pulse on the last cycle of each instruction
- State  out  4  current state encoding, debug/verification

## Operation
- States, encoded 0..9: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
- FETCH:
  - AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10.
  - IRWrite and PCWrite equal MemReady.
  - Next state is DECODE if MemReady, else stay in FETCH.
- DECODE:
  - ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - Decode on Op=Instr[27:26]:
    - 01, memory: →MEMADR.
    - 00, data-processing: Instr[25]=1 →EXECI, else →EXECR.
    - 10, branch: →BRANCH.
    - 11: →FETCH, no writes, Retire=1.
- MEMADR:
  - ALUSrcA=0, ALUSrcB=01, ADD.
  - Instr[20] (L)=1 →MEMREAD, else →MEMWRITE.
- MEMREAD: AdrSrc=1; hold until MemReady, then →MEMWB.
- MEMWRITE:
  - AdrSrc=1, MemWrite=CondEx.
  - Hold MemWrite until MemReady, then →FETCH, Retire=1.
- MEMWB: ResultSrc=01, RegWrite=CondEx; →FETCH, Retire=1.
- EXECR / EXECI:
  - ALUSrcA=0, ALUSrcB=00 or 01, decoded ALUControl.
  - Flags update at the end of this cycle; →ALUWB.
- ALUWB:
  - ResultSrc=00, RegWrite=CondEx & ~NoWrite.
  - PCWrite=CondEx & ~NoWrite & (Rd=Instr[15:12]==15).
  - →FETCH, Retire=1.
- BRANCH:
  - ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx.
  - →FETCH, Retire=1.
- ALU decode on cmd=Instr[24:21]:
  - ADD 0100→0, SUB 0010→1, AND 0000→2, ORR 1100→3, CMP 1010→1 with NoWrite and forced S.
  - With ALUC_W=3: EOR 0001→4, MOV 1101→5, TST 1000→2 with NoWrite and forced S.
  - Unsupported cmd: ALUControl=0, RegWrite, PCWrite and flag write all suppressed.
- Flag write (only in EXECR/EXECI):
  - NZ←ALUFlags[3:2] if S & CondEx.
  - CV←ALUFlags[1:0] if S & CondEx & cmd is ADD/SUB/CMP.
- CondEx uses registered Flags and Instr[31:28], standard ARM EQ..LE. 1110 = always; 1111 = never (the instruction runs its full cycle count as a NOP).
- ImmSrc=Op. RegSrc[0]=(Op==10), RegSrc[1]=(Op==01).
- Unlisted outputs are 0 in each state.

## Timing
- Outputs are Moore-style combinational from State, Instr and Flags. MemReady gates only the FETCH outputs and the stall transitions.
- While reset is high, all enables and Retire are 0 and State=FETCH. The first FETCH occurs in the cycle after reset deasserts.
- Latency with MemReady held at 1: LDR 5 cycles, STR 4, data-processing 4, B 3, Op=11 2.
- Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Outputs stay constant through the stall.
- Reset asserted mid-instruction: the instruction is abandoned, with no write in that or any later cycle.

## Configuration
- ARM_MC_MEMREADY_EN defined: handshake behaviour as specified above.
- ARM_MC_MEMREADY_EN undefined: MemReady is ignored and treated as constant 1, so every memory state takes exactly one cycle.

## Test plan
- Reset, then MemReady=1 with ADD R1,R2,#5 (0xE2821005) → States 0,1,7,8. RegWrite=1 only in ALUWB, ALUControl=0, Retire pulse in cycle 4.
- LDR (0xE5901000) with MemReady low for 2 cycles in MEMREAD → 7 cycles total, RegWrite=1 with ResultSrc=01 only in MEMWB.
- CMP giving Z=1, then BNE (0x1AFFFFFE) → BRANCH with PCWrite=0; then BEQ → PCWrite=1.
- SUBS producing N=1,V=1 sets Flags; following ADD without S leaves Flags unchanged.
- ALUC_W=3 with EOR R0,R0,R1 → ALUControl=4. ALUC_W=2 with the same instruction → RegWrite=0 in ALUWB.
- Reset asserted while in MEMWRITE with MemReady=0 → MemWrite drops to 0 immediately and State=0.
